// File: rtl/tpm_status_display.sv
// Status/readout engine: debounced page button, page FSM with auto-scroll and
// failure blink, and a registered seven-segment / LED output stage.
//
// state     | meaning
// ST_MANUAL | page advances only on a debounced button press
// ST_AUTO   | page advances on scroll-timer expiry or on a press
// ST_FAIL   | op_state is 3'b101; page forced to 0, display blinks
module tpm_status_display #(
  parameter int NUM_CH       = 8,
  parameter int CNT_W        = 32,
  parameter int NUM_DIGITS   = 5,
  parameter int DEB_TICKS    = 500000,
  parameter int SCROLL_TICKS = 50000000,
  parameter int BLINK_TICKS  = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [2:0]              op_state,
  input  logic [NUM_CH*CNT_W-1:0] cnt_bus,
  input  logic                    btn_n,
  input  logic                    auto_en,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [3:0]              page,
  output logic                    overflow,
  output logic                    auto_led
);

  localparam int DEB_W    = (DEB_TICKS > 2) ? $clog2(DEB_TICKS) : 1;
  localparam int SCROLL_W = (SCROLL_TICKS > 2) ? $clog2(SCROLL_TICKS) : 1;
  localparam int BLINK_W  = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam int FW       = 4 * (NUM_DIGITS - 1);
  localparam int EXT_W    = (CNT_W > FW) ? CNT_W : FW;

  localparam logic [DEB_W-1:0]    DEB_RELOAD    = DEB_W'(DEB_TICKS - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_RELOAD = SCROLL_W'(SCROLL_TICKS - 1);
  localparam logic [BLINK_W-1:0]  BLINK_RELOAD  = BLINK_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_FAIL} state_t;

  logic             btn_s1, btn_s2, btn_deb, press;
  logic [DEB_W-1:0] deb_cnt;

  // Counter runs only while the synchronised level disagrees with the
  // debounced level, so any bounce back reloads it.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_deb <= 1'b1;
      deb_cnt <= DEB_RELOAD;
      press   <= 1'b0;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      press  <= 1'b0;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= DEB_RELOAD;
      end else if (deb_cnt == '0) begin
        btn_deb <= btn_s2;
        deb_cnt <= DEB_RELOAD;
        press   <= ~btn_s2;
      end else begin
        deb_cnt <= deb_cnt - 1'b1;
      end
    end
  end

  state_t              state_q, state_n;
  logic [3:0]          page_q, page_n, page_inc;
  logic [SCROLL_W-1:0] scroll_q, scroll_n;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_n;
  logic                blink_vis_q, blink_vis_n;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_MANUAL;
      page_q      <= 4'd0;
      scroll_q    <= SCROLL_RELOAD;
      blink_cnt_q <= BLINK_RELOAD;
      blink_vis_q <= 1'b1;
    end else begin
      state_q     <= state_n;
      page_q      <= page_n;
      scroll_q    <= scroll_n;
      blink_cnt_q <= blink_cnt_n;
      blink_vis_q <= blink_vis_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    page_n      = page_q;
    scroll_n    = scroll_q;
    blink_cnt_n = blink_cnt_q;
    blink_vis_n = blink_vis_q;
    page_inc    = (page_q == 4'(NUM_CH)) ? 4'd0 : page_q + 4'd1;
    if (op_state == 3'b101 && state_q != ST_FAIL) begin
      state_n     = ST_FAIL;
      page_n      = 4'd0;
      blink_cnt_n = BLINK_RELOAD;
      blink_vis_n = 1'b1;
    end else begin
      case (state_q)
        ST_MANUAL: begin
          if (press) page_n = page_inc;
          if (auto_en) begin
            state_n  = ST_AUTO;
            scroll_n = SCROLL_RELOAD;
          end
        end
        ST_AUTO: begin
          if (!auto_en) begin
            state_n = ST_MANUAL;
            if (press) page_n = page_inc;
          end else if (press || scroll_q == '0) begin
            page_n   = page_inc;
            scroll_n = SCROLL_RELOAD;
          end else begin
            scroll_n = scroll_q - 1'b1;
          end
        end
        ST_FAIL: begin
          if (op_state != 3'b101) begin
            state_n  = auto_en ? ST_AUTO : ST_MANUAL;
            page_n   = 4'd0;
            scroll_n = SCROLL_RELOAD;
          end else if (blink_cnt_q == '0) begin
            blink_vis_n = ~blink_vis_q;
            blink_cnt_n = BLINK_RELOAD;
          end else begin
            blink_cnt_n = blink_cnt_q - 1'b1;
          end
        end
        default: state_n = ST_MANUAL;
      endcase
    end
  end

  logic [CNT_W-1:0]        ch_sel;
  logic [EXT_W-1:0]        ch_ext;
  logic [19:0]             mnem;
  logic [4*NUM_DIGITS-1:0] digits_n;
  logic [NUM_DIGITS-1:0]   blank_n;
  logic                    overflow_n;

  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (page_q == 4'(k + 1)) ch_sel = cnt_bus[k*CNT_W +: CNT_W];
    end
    ch_ext = EXT_W'(ch_sel);
    case (op_state)
      3'b000:  mnem = 20'h20FF5;
      3'b001:  mnem = 20'h17195;
      3'b010:  mnem = 20'h59A89;
      3'b011:  mnem = 20'h02E89;
      3'b100:  mnem = 20'h5E6F9;
      3'b101:  mnem = 20'hFA165;
      3'b110:  mnem = 20'h53495;
      default: mnem = 20'h00000;
    endcase
    blank_n = '0;
    if (page_q == 4'd0) begin
      digits_n     = (4*NUM_DIGITS)'(mnem);
      overflow_n   = 1'b0;
      blank_n      = '1;
      blank_n[4:0] = 5'b00000;
    end else begin
      digits_n   = {page_q, ch_ext[FW-1:0]};
      overflow_n = |(ch_ext >> FW);
    end
    if (state_q == ST_FAIL && !blink_vis_q) blank_n = '1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      digits   <= '0;
      blank    <= '1;
      overflow <= 1'b0;
      auto_led <= 1'b0;
    end else begin
      digits   <= digits_n;
      blank    <= blank_n;
      overflow <= overflow_n;
      auto_led <= (state_q == ST_AUTO) || (state_q == ST_FAIL && auto_en);
    end
  end

  assign page = page_q;

endmodule

// File: tb/tb_tpm_status_display.sv
// Randomized bench for tpm_status_display with a page/content reference model
// and a page-change log for auto-scroll interval checks.
module tb_tpm_status_display;

  localparam int NCH = 8, DEB = 4, SCR = 10, BLK = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op_state;
  logic [255:0]  cnt_bus;
  logic          btn_n, auto_en;
  logic [19:0]   digits;
  logic [4:0]    blank;
  logic [3:0]    page;
  logic          overflow, auto_led;

  tpm_status_display #(
    .NUM_CH(NCH), .CNT_W(32), .NUM_DIGITS(5),
    .DEB_TICKS(DEB), .SCROLL_TICKS(SCR), .BLINK_TICKS(BLK)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .op_state(op_state), .cnt_bus(cnt_bus),
    .btn_n(btn_n), .auto_en(auto_en), .digits(digits), .blank(blank),
    .page(page), .overflow(overflow), .auto_led(auto_led)
  );

  always #5 clk = ~clk;

  logic [31:0] cnt [NCH];
  logic [19:0] mnem_tbl [8] = '{20'h20FF5, 20'h17195, 20'h59A89, 20'h02E89,
                                20'h5E6F9, 20'hFA165, 20'h53495, 20'h00000};

  always_comb for (int k = 0; k < NCH; k++) cnt_bus[k*32 +: 32] = cnt[k];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, mpage = 0, mon_last = 0;
  bit mon_en = 0;
  int chg_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle; logs and checks page changes while auto-scroll is monitored.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_en && int'(page) != mon_last) begin
      chk("page_step", 32'(page), 32'((mon_last + 1) % (NCH + 1)));
      mpage = (mpage + 1) % (NCH + 1);
      chg_q.push_back(cyc);
    end
    mon_last = int'(page);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [19:0] exp_digits(input int p, input logic [2:0] op);
    if (p == 0) return mnem_tbl[op];
    return 20'((p << 16) | (cnt[p-1] & 32'hFFFF));
  endfunction

  function automatic logic exp_ovf(input int p);
    return (p != 0) && ((cnt[p-1] >> 16) != 0);
  endfunction

  task automatic check_view(input string tag);
    chk({tag, "_page"}, 32'(page), 32'(mpage));
    chk({tag, "_digits"}, 32'(digits), 32'(exp_digits(mpage, op_state)));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf(mpage)));
    chk({tag, "_blank"}, 32'(blank), 32'h0);
  endtask

  task automatic press_manual(input int hold);
    btn_n = 1'b0;
    ticks(hold);
    btn_n = 1'b1;
    ticks(DEB + 4);
    mpage = (mpage + 1) % (NCH + 1);
  endtask

  task automatic glitch(input int len);
    btn_n = 1'b0;
    ticks(len);
    btn_n = 1'b1;
    ticks(DEB + 3);
  endtask

  // Waits for the next logged page change; an expired bound counts as a failure.
  task automatic wait_change(output int t);
    int n0;
    n0 = chg_q.size();
    t = -1;
    for (int i = 0; i < 3 * SCR && chg_q.size() == n0; i++) tick();
    if (chg_q.size() == n0) chk("wait_change_timeout", 32'd0, 32'd1);
    else t = chg_q[$];
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tset, short_trials, full_trials;
    reset = 1'b1; op_state = 3'b011; btn_n = 1'b1; auto_en = 1'b0;
    for (int k = 0; k < NCH; k++) cnt[k] = 32'h0;
    ticks(3);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_blank", 32'(blank), 32'h1F);
    chk("rst_page", 32'(page), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_led", 32'(auto_led), 32'h0);
    reset = 1'b0;
    ticks(2);
    check_view("rel");

    cnt[0] = 32'h0001_2345;
    glitch(3);
    chk("glitch_page", 32'(page), 32'h0);
    press_manual(10);
    check_view("p1");
    chk("p1_const", 32'(digits), 32'h12345);
    chk("p1_ovf_const", 32'(overflow), 32'h1);

    cnt[7] = 32'h0000_BEEF;
    for (int i = 0; i < 9; i++) begin
      press_manual(DEB + 4);
      check_view("wrap");
      if (mpage == 8) chk("p8_const", 32'(digits), 32'h8BEEF);
    end

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NCH; k++)
        cnt[k] = $urandom() & ($urandom_range(0, 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      op_state = 3'($urandom_range(0, 7));
      if (op_state == 3'b101) op_state = 3'b110;
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
        glitch($urandom_range(1, DEB - 1));
        press_manual($urandom_range(DEB + 4, DEB + 30));
        check_view("rnd");
      end
    end

    btn_n = 1'b0;
    ticks(DEB - 1);
    reset = 1'b1;
    tick();
    btn_n = 1'b1;
    reset = 1'b0;
    mpage = 0;
    ticks(DEB + 8);
    chk("rst_mid_page", 32'(page), 32'h0);

    op_state = 3'b011;
    mon_last = int'(page);
    mon_en = 1;
    auto_en = 1'b1;
    tset = cyc;
    wait_change(t0);
    chk("auto_first", 32'(t0 - tset), 32'd11);
    chk("auto_led_on", 32'(auto_led), 32'h1);
    for (int i = 0; i < 4; i++) begin
      int t1;
      wait_change(t1);
      chk("auto_period", 32'(t1 - t0), 32'(SCR));
      t0 = t1;
    end

    short_trials = 0;
    full_trials = 0;
    for (int off = 0; off < SCR; off++) begin
      int nshort;
      wait_change(t0);
      ticks(off);
      btn_n = 1'b0;
      ticks(DEB + 3);
      btn_n = 1'b1;
      ticks(DEB + 4 + 25);
      nshort = 0;
      for (int j = 1; j < chg_q.size(); j++) begin
        if (chg_q[j-1] >= t0) begin
          int d;
          d = chg_q[j] - chg_q[j-1];
          if (d < 1 || d > SCR) chk("auto_interval", 32'(d), 32'(SCR));
          if (d < SCR) nshort++;
        end
      end
      if (nshort == 0) full_trials++;
      else if (nshort == 1) short_trials++;
    end
    chk("coincide_trials", 32'(full_trials), 32'd1);
    chk("early_trials", 32'(short_trials), 32'(SCR - 1));

    wait_change(t0);
    auto_en = 1'b0;
    ticks(SCR + 5);
    chk("manual_keep_page", 32'(page), 32'(mpage));
    chk("auto_led_off", 32'(auto_led), 32'h0);
    mon_en = 0;

    for (int i = 0; i <= NCH && mpage != 3; i++) press_manual(DEB + 4);
    check_view("pre_fail");
    op_state = 3'b101;
    tick();
    for (int i = 0; i < 30; i++) begin
      if (i == 3) btn_n = 1'b0;
      if (i == 14) btn_n = 1'b1;
      tick();
      chk("fail_page", 32'(page), 32'h0);
      chk("fail_digits", 32'(digits), 32'hFA165);
      chk("fail_blank", 32'(blank), ((i / BLK) % 2) ? 32'h1F : 32'h0);
    end
    btn_n = 1'b1;
    ticks(DEB + 4);
    chk("fail_press_ign", 32'(page), 32'h0);
    chk("fail_led_off", 32'(auto_led), 32'h0);
    auto_en = 1'b1;
    ticks(2);
    chk("fail_led_follow", 32'(auto_led), 32'h1);
    auto_en = 1'b0;
    ticks(2);

    op_state = 3'b011;
    ticks(3);
    mpage = 0;
    check_view("exit");
    chk("exit_led", 32'(auto_led), 32'h0);
    press_manual(DEB + 4);
    check_view("exit_press");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
